// File: rtl/deser_fifo_pkg.sv
// Shared types, default parameters and helper functions for the serial
// deserializer with output FIFO. Optional parity checking is enabled by
// defining DESER_PARITY_EN.
package deser_fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 8;
   localparam int AF_LVL_DEF = DEPTH_DEF - 2;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_PUSH    = 2'd1,
      S_PARITY  = 2'd2
   } deser_state_t;

   // Count width able to hold 0..depth inclusive.
   function automatic int len_w_f(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Even parity of a word (XOR of all bits); zero-extension is harmless.
   function automatic logic even_parity_f(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/sync_fifo_ff.sv
// Flip-flop based synchronous FIFO with first-word fall-through read.
// Keeps an explicit occupancy count so full and empty are unambiguous.
// A push is accepted when not full, or when a pop happens on the same edge.
module sync_fifo_ff
   import deser_fifo_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   localparam int LEN_W  = len_w_f(DEPTH),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic              push_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [LEN_W-1:0]  len
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LEN_W-1:0]  len_r;
   logic              empty_s;
   logic              full_s;
   logic              pop_ok_s;
   logic              push_ok_s;

   assign empty_s   = (len_r == LEN_W'(0));
   assign full_s    = (len_r == LEN_W'(DEPTH));
   assign pop_ok_s  = pop & ~empty_s;
   assign push_ok_s = push & (~full_s | pop_ok_s);

   assign push_ack = push_ok_s;
   assign len      = len_r;
   assign rdata    = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         len_r    <= LEN_W'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   len_r <= len_r + LEN_W'(1);
            2'b01:   len_r <= len_r - LEN_W'(1);
            default: len_r <= len_r;
         endcase
      end
   end

   // Word storage; contents are only visible through rdata when non-empty.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/deser_fifo_ctrl.sv
// Serial-to-parallel deserializer feeding a FIFO. Bits arrive LSB first on
// rising edges of write_in; completed words are pushed into sync_fifo_ff and
// popped by rising edges of dequeue_in. A full FIFO stalls the deserializer
// (word held) and any bit strobe during the stall raises overrun_out.
// Define DESER_PARITY_EN to expect an even-parity bit after every word.
module deser_fifo_ctrl
   import deser_fifo_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   parameter int  AF_LVL = DEPTH - 2,
   localparam int LEN_W  = len_w_f(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              data_in,
   input  logic              write_in,
   output logic              status_out,
   input  logic              dequeue_in,
   output logic [DATA_W-1:0] data_out,
   output logic [LEN_W-1:0]  len_out,
   output logic              almost_full_out,
   output logic              overrun_out,
   output logic              parity_err_out
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   deser_state_t      state_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [DATA_W-1:0] shift_r;
   logic              status_r;
   logic              overrun_r;
   logic              write_q;
   logic              dequeue_q;
   logic              wr_rise_s;
   logic              dq_rise_s;
   logic              push_s;
   logic              push_ack_s;

   assign wr_rise_s = write_in & ~write_q;
   assign dq_rise_s = dequeue_in & ~dequeue_q;
   assign push_s    = (state_r == S_PUSH);

   // Previous strobe levels for rising-edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_q   <= 1'b0;
         dequeue_q <= 1'b0;
      end else begin
         write_q   <= write_in;
         dequeue_q <= dequeue_in;
      end
   end

`ifdef DESER_PARITY_EN
   logic parity_err_r;
   assign parity_err_out = parity_err_r;
`else
   assign parity_err_out = 1'b0;
`endif

   // Deserializer FSM with registered status, overrun and parity-error outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= S_COLLECT;
         bit_cnt_r    <= CNT_W'(0);
         shift_r      <= {DATA_W{1'b0}};
         status_r     <= 1'b1;
         overrun_r    <= 1'b0;
`ifdef DESER_PARITY_EN
         parity_err_r <= 1'b0;
`endif
      end else begin
         overrun_r    <= 1'b0;
`ifdef DESER_PARITY_EN
         parity_err_r <= 1'b0;
`endif
         case (state_r)
            S_COLLECT: begin
               if (wr_rise_s) begin
                  shift_r[bit_cnt_r] <= data_in;
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_r <= CNT_W'(0);
                     status_r  <= 1'b0;
`ifdef DESER_PARITY_EN
                     state_r   <= S_PARITY;
`else
                     state_r   <= S_PUSH;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
               end
            end
            S_PUSH: begin
               // Bits arriving while the word waits for space are discarded.
               overrun_r <= wr_rise_s;
               if (push_ack_s) begin
                  state_r  <= S_COLLECT;
                  status_r <= 1'b1;
               end
            end
            S_PARITY: begin
`ifdef DESER_PARITY_EN
               if (wr_rise_s) begin
                  if (data_in == even_parity_f(32'(shift_r))) begin
                     state_r <= S_PUSH;
                  end else begin
                     parity_err_r <= 1'b1;
                     state_r      <= S_COLLECT;
                     status_r     <= 1'b1;
                  end
               end
`else
               state_r  <= S_COLLECT;
               status_r <= 1'b1;
`endif
            end
            default: begin
               state_r   <= S_COLLECT;
               bit_cnt_r <= CNT_W'(0);
               status_r  <= 1'b1;
            end
         endcase
      end
   end

   assign status_out      = status_r;
   assign overrun_out     = overrun_r;
   assign almost_full_out = (len_out >= LEN_W'(AF_LVL));

   sync_fifo_ff #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push_s),
      .wdata    (shift_r),
      .pop      (dq_rise_s),
      .push_ack (push_ack_s),
      .rdata    (data_out),
      .len      (len_out)
   );

endmodule

// File: tb/tb_deser_fifo_ctrl.sv
// Scoreboard bench for deser_fifo_ctrl: words are queued as they are sent and
// compared against the FIFO head as they are popped.
`timescale 1ns/1ps
module tb_deser_fifo_ctrl;
   import deser_fifo_pkg::*;

   localparam int DW = 8;
   localparam int DP = 8;
   localparam int AF = 6;
   localparam int LW = len_w_f(DP);

   logic          clock = 1'b0;
   logic          reset;
   logic          data_in;
   logic          write_in;
   logic          dequeue_in;
   logic          status_out;
   logic          almost_full_out;
   logic          overrun_out;
   logic          parity_err_out;
   logic [DW-1:0] data_out;
   logic [LW-1:0] len_out;

   int            n_checks = 0;
   int            n_pass   = 0;
   int            ovr_cnt  = 0;
   int            perr_cnt = 0;
   logic [DW-1:0] exp_q [$];

   always #5 clock = ~clock;

   deser_fifo_ctrl #(.DATA_W(DW), .DEPTH(DP), .AF_LVL(AF)) dut (
      .clock           (clock),
      .reset           (reset),
      .data_in         (data_in),
      .write_in        (write_in),
      .status_out      (status_out),
      .dequeue_in      (dequeue_in),
      .data_out        (data_out),
      .len_out         (len_out),
      .almost_full_out (almost_full_out),
      .overrun_out     (overrun_out),
      .parity_err_out  (parity_err_out)
   );

   // Count cycles in which the pulse outputs are high.
   always @(negedge clock) begin
      if (overrun_out === 1'b1) ovr_cnt <= ovr_cnt + 1;
      if (parity_err_out === 1'b1) perr_cnt <= perr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send_bit(input logic b);
      data_in  = b;
      write_in = 1'b1;
      repeat (10) @(negedge clock);
      write_in = 1'b0;
      repeat (10) @(negedge clock);
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      for (int i = 0; i < DW; i++) send_bit(w[i]);
`ifdef DESER_PARITY_EN
      send_bit(^w);
`endif
      exp_q.push_back(w);
   endtask

   function automatic int exp_len();
      return (exp_q.size() > DP) ? DP : exp_q.size();
   endfunction

   task automatic pop_word(input string tag, input int hold);
      logic [DW-1:0] exp_v;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         exp_v = exp_q.pop_front();
         check_eq({tag, "_head"}, 32'(data_out), 32'(exp_v));
      end
      dequeue_in = 1'b1;
      repeat (hold) @(negedge clock);
      dequeue_in = 1'b0;
      repeat (4) @(negedge clock);
      check_eq({tag, "_len"}, 32'(len_out), 32'(exp_len()));
   endtask

   initial begin
      logic [DW-1:0] w80;
      int            base;
      reset      = 1'b1;
      data_in    = 1'b0;
      write_in   = 1'b0;
      dequeue_in = 1'b0;
      w80        = 8'h80;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst_len", 32'(len_out), 32'd0);
      check_eq("rst_data", 32'(data_out), 32'd0);
      check_eq("rst_status", 32'(status_out), 32'd1);
      check_eq("rst_af", 32'(almost_full_out), 32'd0);
      check_eq("rst_ovr", 32'(overrun_out), 32'd0);
      check_eq("rst_perr", 32'(parity_err_out), 32'd0);

      // Single word 0x80; last strobe timed by hand to check one-edge latency.
      for (int i = 0; i < 7; i++) send_bit(w80[i]);
`ifdef DESER_PARITY_EN
      send_bit(w80[7]);
`endif
      data_in  = 1'b1;
      write_in = 1'b1;
      @(negedge clock);
      check_eq("t1_status_busy", 32'(status_out), 32'd0);
      check_eq("t1_len_before", 32'(len_out), 32'd0);
      @(negedge clock);
      exp_q.push_back(8'h80);
      check_eq("t1_len", 32'(len_out), 32'd1);
      check_eq("t1_data", 32'(data_out), 32'h80);
      check_eq("t1_status", 32'(status_out), 32'd1);
      repeat (8) @(negedge clock);
      write_in = 1'b0;
      repeat (10) @(negedge clock);

      // Three more words, then a long dequeue strobe must pop exactly once.
      for (int i = 1; i < 4; i++) send_word(DW'(8'h80 + i));
      check_eq("t2_len4", 32'(len_out), 32'd4);
      pop_word("t2_pop", 200);
      check_eq("t2_head81", 32'(data_out), 32'h81);
      for (int i = 0; i < 3; i++) pop_word("t2_drain", 3);
      check_eq("t2_empty_data", 32'(data_out), 32'd0);
      dequeue_in = 1'b1;
      repeat (3) @(negedge clock);
      dequeue_in = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("underflow_len", 32'(len_out), 32'd0);

      // Fill past capacity; the ninth word stalls in the deserializer.
      for (int i = 0; i < 9; i++) begin
         send_word(DW'(8'h10 + i));
         check_eq("t3_len", 32'(len_out), 32'(exp_len()));
         check_eq("t3_af", 32'(almost_full_out), 32'(exp_len() >= AF));
      end
      check_eq("t3_status_stall", 32'(status_out), 32'd0);

      // Strobes during the stall are dropped with a one-cycle overrun each.
      base = ovr_cnt;
      send_bit(1'b1);
      check_eq("t4_ovr1", 32'(ovr_cnt - base), 32'd1);
      send_bit(1'b0);
      check_eq("t4_ovr2", 32'(ovr_cnt - base), 32'd2);
      check_eq("t4_len", 32'(len_out), 32'd8);
      check_eq("t4_status", 32'(status_out), 32'd0);

      pop_word("t3_pop_full", 5);
      check_eq("t3_status_resume", 32'(status_out), 32'd1);
      for (int i = 0; i < 8; i++) pop_word("t3_drain", 5);
      check_eq("t3_final_len", 32'(len_out), 32'd0);

      // Reset in the middle of a word clears FIFO and partial bits.
      send_word(8'h33);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check_eq("t5_len_rst", 32'(len_out), 32'd0);
      check_eq("t5_status_rst", 32'(status_out), 32'd1);
      send_word(8'h5A);
      check_eq("t5_len", 32'(len_out), 32'd1);
      check_eq("t5_data", 32'(data_out), 32'h5A);
      pop_word("t5_pop", 3);

`ifdef DESER_PARITY_EN
      // Good parity accepted, bad parity dropped with a single error pulse.
      send_word(8'h03);
      check_eq("t6_len_good", 32'(len_out), 32'd1);
      base = perr_cnt;
      for (int i = 0; i < DW; i++) send_bit((i < 2) ? 1'b1 : 1'b0);
      send_bit(1'b1);
      check_eq("t6_perr", 32'(perr_cnt - base), 32'd1);
      check_eq("t6_len_bad", 32'(len_out), 32'd1);
      check_eq("t6_status", 32'(status_out), 32'd1);
      pop_word("t6_pop", 3);
`else
      check_eq("perr_never", 32'(perr_cnt), 32'd0);
`endif
      check_eq("ovr_total", 32'(ovr_cnt), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
